// File: rtl/c4_board_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : c4_board_engine                                                  |
// | Brief   : Connect Four board store and rules engine. Gravity drop of one   |
// |           piece per request, exhaustive four-in-a-row scan per request,    |
// |           and a registered cell-read port for the display.                 |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module c4_board_engine #(
   parameter int ROWS = 6,   // row 0 is the bottom row, ROWS <= 8
   parameter int COLS = 7    // column 0 is leftmost, COLS <= 8
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       drop_a_piece,
   input  logic [2:0] col,
   input  logic       turn,
   input  logic       check_for_winner,
   output logic       done_drop_piece,
   output logic       drop_ok,
   output logic       done_check_winner,
   output logic       winner,
   output logic       board_full,
   input  logic [2:0] rd_row,
   input  logic [2:0] rd_col,
   output logic [1:0] rd_cell
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [3:0]        COLS_U   = 4'(COLS);
   localparam logic [2:0]        ROW_LAST = 3'(ROWS - 1);
   localparam logic [2:0]        COL_LAST = 3'(COLS - 1);
   localparam logic signed [4:0] ROWS_S   = 5'(ROWS);
   localparam logic signed [4:0] COLS_S   = 5'(COLS);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_DROP_SCAN = 3'd1,
      S_DROP_DONE = 3'd2,
      S_WIN_SCAN  = 3'd3,
      S_WIN_DONE  = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic       drop_prev_q, check_prev_q;
   logic [2:0] col_q, col_d;
   logic       turn_q, turn_d;
   logic [2:0] row_q, row_d;
   logic [2:0] scan_r_q, scan_r_d;
   logic [2:0] scan_c_q, scan_c_d;
   logic [1:0] dir_q, dir_d;
   logic       done_drop_q, done_drop_d;
   logic       drop_ok_q, drop_ok_d;
   logic       done_check_q, done_check_d;
   logic       winner_q, winner_d;
   logic [1:0] rd_cell_q;
   logic [1:0] board_q [ROWS][COLS];

   logic              w_drop_start, w_check_start;
   logic              w_wr_en;
   logic [1:0]        w_wr_code;
   logic [1:0]        w_drop_cell;
   logic              w_pair_hit, w_scan_last;
   logic signed [4:0] w_dr, w_dc, w_r0, w_c0;
   logic [1:0]        w_p0, w_p1, w_p2, w_p3;

   // Bounds-checked cell lookup; anything off the grid reads as empty, so a
   // line running off any edge can never match a real piece.
   function automatic logic [1:0] cell_at(input logic signed [4:0] r,
                                          input logic signed [4:0] c);
      logic [1:0] v;
      v = 2'b00;
      if ((r >= 5'sd0) && (r < ROWS_S) && (c >= 5'sd0) && (c < COLS_S))
         v = board_q[r[RW-1:0]][c[CW-1:0]];
      return v;
   endfunction

   assign w_drop_start  = drop_a_piece & ~drop_prev_q;
   assign w_check_start = check_for_winner & ~check_prev_q;
   assign w_drop_cell   = cell_at(signed'({2'b00, row_q}), signed'({2'b00, col_q}));
   assign w_wr_code     = turn_q ? 2'b10 : 2'b01;
   assign w_scan_last   = (scan_r_q == ROW_LAST) && (scan_c_q == COL_LAST) && (dir_q == 2'd3);

   // Evaluate the current (cell, direction) pair of the win scan.
   always_comb begin
      w_dr = 5'sd0;
      w_dc = 5'sd1;
      case (dir_q)
         2'd0:    begin w_dr = 5'sd0; w_dc = 5'sd1;  end
         2'd1:    begin w_dr = 5'sd1; w_dc = 5'sd0;  end
         2'd2:    begin w_dr = 5'sd1; w_dc = 5'sd1;  end
         default: begin w_dr = 5'sd1; w_dc = -5'sd1; end
      endcase
      w_r0 = signed'({2'b00, scan_r_q});
      w_c0 = signed'({2'b00, scan_c_q});
      w_p0 = cell_at(w_r0, w_c0);
      w_p1 = cell_at(w_r0 + w_dr, w_c0 + w_dc);
      w_p2 = cell_at(w_r0 + w_dr + w_dr, w_c0 + w_dc + w_dc);
      w_p3 = cell_at(w_r0 + w_dr + w_dr + w_dr, w_c0 + w_dc + w_dc + w_dc);
      w_pair_hit = (w_p0 != 2'b00) && (w_p0 == w_p1) && (w_p0 == w_p2) && (w_p0 == w_p3);
   end

   // Next-state and handshake logic for drop and win-scan operations.
   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      turn_d       = turn_q;
      row_d        = row_q;
      scan_r_d     = scan_r_q;
      scan_c_d     = scan_c_q;
      dir_d        = dir_q;
      done_drop_d  = done_drop_q;
      drop_ok_d    = drop_ok_q;
      done_check_d = done_check_q;
      winner_d     = winner_q;
      w_wr_en      = 1'b0;
      case (state_q)
         S_IDLE: begin
            // A simultaneous check request is dropped; drop has priority.
            if (w_drop_start) begin
               col_d     = col;
               turn_d    = turn;
               row_d     = 3'd0;
               drop_ok_d = 1'b0;
               state_d   = S_DROP_SCAN;
            end else if (w_check_start) begin
               winner_d = 1'b0;
               scan_r_d = 3'd0;
               scan_c_d = 3'd0;
               dir_d    = 2'd0;
               state_d  = S_WIN_SCAN;
            end
         end
         S_DROP_SCAN: begin
            if ({1'b0, col_q} >= COLS_U) begin
               drop_ok_d   = 1'b0;
               done_drop_d = 1'b1;
               state_d     = S_DROP_DONE;
            end else if (w_drop_cell == 2'b00) begin
               w_wr_en     = 1'b1;
               drop_ok_d   = 1'b1;
               done_drop_d = 1'b1;
               state_d     = S_DROP_DONE;
            end else if (row_q == ROW_LAST) begin
               drop_ok_d   = 1'b0;
               done_drop_d = 1'b1;
               state_d     = S_DROP_DONE;
            end else begin
               row_d = row_q + 3'd1;
            end
         end
         S_DROP_DONE: begin
            if (!drop_a_piece) begin
               done_drop_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         S_WIN_SCAN: begin
            if (w_pair_hit) begin
               winner_d     = 1'b1;
               done_check_d = 1'b1;
               state_d      = S_WIN_DONE;
            end else if (w_scan_last) begin
               winner_d     = 1'b0;
               done_check_d = 1'b1;
               state_d      = S_WIN_DONE;
            end else begin
               // Direction varies fastest, then column, then row.
               dir_d = dir_q + 2'd1;
               if (dir_q == 2'd3) begin
                  if (scan_c_q == COL_LAST) begin
                     scan_c_d = 3'd0;
                     scan_r_d = scan_r_q + 3'd1;
                  end else begin
                     scan_c_d = scan_c_q + 3'd1;
                  end
               end
            end
         end
         S_WIN_DONE: begin
            if (!check_for_winner) begin
               done_check_d = 1'b0;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control and output registers.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q      <= S_IDLE;
         drop_prev_q  <= 1'b0;
         check_prev_q <= 1'b0;
         col_q        <= 3'd0;
         turn_q       <= 1'b0;
         row_q        <= 3'd0;
         scan_r_q     <= 3'd0;
         scan_c_q     <= 3'd0;
         dir_q        <= 2'd0;
         done_drop_q  <= 1'b0;
         drop_ok_q    <= 1'b0;
         done_check_q <= 1'b0;
         winner_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         drop_prev_q  <= drop_a_piece;
         check_prev_q <= check_for_winner;
         col_q        <= col_d;
         turn_q       <= turn_d;
         row_q        <= row_d;
         scan_r_q     <= scan_r_d;
         scan_c_q     <= scan_c_d;
         dir_q        <= dir_d;
         done_drop_q  <= done_drop_d;
         drop_ok_q    <= drop_ok_d;
         done_check_q <= done_check_d;
         winner_q     <= winner_d;
      end
   end

   // Board storage: cleared on reset, one gravity write per successful drop.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
               board_q[r][c] <= 2'b00;
      end else if (w_wr_en) begin
         board_q[row_q[RW-1:0]][col_q[CW-1:0]] <= w_wr_code;
      end
   end

   // Display read port, one cycle of latency, empty when off the grid.
   always_ff @(posedge CLOCK_50) begin
      if (reset)
         rd_cell_q <= 2'b00;
      else
         rd_cell_q <= cell_at(signed'({2'b00, rd_row}), signed'({2'b00, rd_col}));
   end

   // Board is full once every top-row cell holds a piece.
   always_comb begin
      board_full = 1'b1;
      for (int c = 0; c < COLS; c++)
         if (board_q[ROWS-1][c] == 2'b00)
            board_full = 1'b0;
   end

   assign done_drop_piece   = done_drop_q;
   assign drop_ok           = drop_ok_q;
   assign done_check_winner = done_check_q;
   assign winner            = winner_q;
   assign rd_cell           = rd_cell_q;

endmodule
`default_nettype wire

// File: tb/tb_c4_board_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_c4_board_engine                                               |
// | Brief   : Self-checking bench for c4_board_engine with a board-level model |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_c4_board_engine;

   localparam int ROWS = 6;
   localparam int COLS = 7;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       drop_a_piece = 1'b0;
   logic [2:0] col = 3'd0;
   logic       turn = 1'b0;
   logic       check_for_winner = 1'b0;
   logic       done_drop_piece, drop_ok, done_check_winner, winner, board_full;
   logic [2:0] rd_row, rd_col;
   logic [1:0] rd_cell;

   int checks = 0;
   int failures = 0;
   int mdl [ROWS][COLS];
   int exp_drop_ok = 0;
   int exp_winner = 0;
   bit mon_en = 1'b0;
   int rd_mode = 0;       // 0 random, 1 sweep all addresses, 2 fixed
   int fix_row = 0;
   int fix_col = 0;

   c4_board_engine #(.ROWS(ROWS), .COLS(COLS)) dut (
      .CLOCK_50(clk),
      .reset(reset),
      .drop_a_piece(drop_a_piece),
      .col(col),
      .turn(turn),
      .check_for_winner(check_for_winner),
      .done_drop_piece(done_drop_piece),
      .drop_ok(drop_ok),
      .done_check_winner(done_check_winner),
      .winner(winner),
      .board_full(board_full),
      .rd_row(rd_row),
      .rd_col(rd_col),
      .rd_cell(rd_cell)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int expv);
      checks++;
      if (got !== expv) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, expv, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int mcell(input int r, input int c);
      if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 0;
      return mdl[r][c];
   endfunction

   function automatic int height(input int c);
      int h = 0;
      for (int r = 0; r < ROWS; r++) if (mdl[r][c] != 0) h++;
      return h;
   endfunction

   function automatic int model_full();
      for (int c = 0; c < COLS; c++) if (mdl[ROWS-1][c] == 0) return 0;
      return 1;
   endfunction

   // Walk pairs in scan order; result latency is pairs examined + 1.
   function automatic void model_scan(output int win, output int lat);
      int k = 0;
      int dr, dc, v;
      bit same;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            for (int d = 0; d < 4; d++) begin
               case (d)
                  0: begin dr = 0; dc = 1; end
                  1: begin dr = 1; dc = 0; end
                  2: begin dr = 1; dc = 1; end
                  default: begin dr = 1; dc = -1; end
               endcase
               v = mcell(r, c);
               same = (v != 0);
               for (int i = 1; i < 4; i++)
                  if (mcell(r + i*dr, c + i*dc) != v) same = 0;
               if (same) begin
                  win = 1;
                  lat = k + 2;
                  return;
               end
               k++;
            end
      win = 0;
      lat = k + 1;
   endfunction

   function automatic void model_clear();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) mdl[r][c] = 0;
      exp_drop_ok = 0;
      exp_winner = 0;
   endfunction

   // ---------------- read-address driver ----------------
   initial begin
      int sweep_idx = 0;
      rd_row = 3'd0;
      rd_col = 3'd0;
      forever begin
         @(posedge clk); #1;
         if (rd_mode == 1) begin
            rd_row = 3'((sweep_idx >> 3) & 7);
            rd_col = 3'(sweep_idx & 7);
            sweep_idx++;
         end else begin
            sweep_idx = 0;
            if (rd_mode == 2) begin
               rd_row = 3'(fix_row);
               rd_col = 3'(fix_col);
            end else begin
               rd_row = 3'($urandom_range(0, 7));
               rd_col = 3'($urandom_range(0, 7));
            end
         end
      end
   end

   // ---------------- continuous compare while idle ----------------
   initial begin
      int ar, ac, ecell;
      bit en;
      forever begin
         @(posedge clk);
         ar = int'(rd_row);
         ac = int'(rd_col);
         en = mon_en;
         @(negedge clk);
         if (en && mon_en) begin
            ecell = mcell(ar, ac);
            chk("rd_cell", int'(rd_cell), ecell);
            chk("board_full", int'(board_full), model_full());
            chk("idle_done_drop", int'(done_drop_piece), 0);
            chk("idle_done_check", int'(done_check_winner), 0);
            chk("idle_drop_ok", int'(drop_ok), exp_drop_ok);
            chk("idle_winner", int'(winner), exp_winner);
         end
      end
   end

   // ---------------- transaction tasks ----------------
   task automatic settle();
      repeat (2) @(posedge clk);
      #1 mon_en = 1'b1;
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      drop_a_piece = 1'b0;
      check_for_winner = 1'b0;
      @(posedge clk); #1;
      chk("rst_done_drop", int'(done_drop_piece), 0);
      chk("rst_drop_ok", int'(drop_ok), 0);
      chk("rst_done_check", int'(done_check_winner), 0);
      chk("rst_winner", int'(winner), 0);
      chk("rst_rd_cell", int'(rd_cell), 0);
      chk("rst_board_full", int'(board_full), 0);
      reset = 1'b0;
      model_clear();
      settle();
   endtask

   task automatic do_drop(input int c, input int t, output int lat, output int ok);
      int h, e_ok, e_lat, hold;
      h = (c < COLS) ? height(c) : 0;
      e_ok = (c < COLS && h < ROWS) ? 1 : 0;
      e_lat = (c >= COLS) ? 2 : ((h < ROWS) ? h + 2 : ROWS + 1);
      mon_en = 1'b0;
      @(posedge clk); #1;
      drop_a_piece = 1'b1;
      col = 3'(c);
      turn = t[0];
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!done_drop_piece && lat < 40);
      chk("drop_latency", lat, e_lat);
      chk("drop_ok", int'(drop_ok), e_ok);
      ok = int'(drop_ok);
      hold = $urandom_range(0, 3);
      repeat (hold) @(posedge clk);
      #1;
      chk("drop_done_held", int'(done_drop_piece), 1);
      drop_a_piece = 1'b0;
      @(posedge clk); #1;
      chk("drop_done_release", int'(done_drop_piece), 0);
      chk("drop_ok_after", int'(drop_ok), e_ok);
      if (e_ok == 1) mdl[h][c] = (t != 0) ? 2 : 1;
      exp_drop_ok = e_ok;
      settle();
   endtask

   task automatic do_check(output int lat, output int win);
      int e_win, e_lat, hold;
      model_scan(e_win, e_lat);
      mon_en = 1'b0;
      @(posedge clk); #1;
      check_for_winner = 1'b1;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!done_check_winner && lat < 400);
      chk("check_latency", lat, e_lat);
      chk("winner", int'(winner), e_win);
      win = int'(winner);
      hold = $urandom_range(0, 3);
      repeat (hold) @(posedge clk);
      #1;
      chk("check_done_held", int'(done_check_winner), 1);
      chk("winner_held", int'(winner), e_win);
      check_for_winner = 1'b0;
      @(posedge clk); #1;
      chk("check_done_release", int'(done_check_winner), 0);
      chk("winner_after", int'(winner), e_win);
      exp_winner = e_win;
      settle();
   endtask

   task automatic read_cell(input int r, input int c, output int v);
      fix_row = r;
      fix_col = c;
      rd_mode = 2;
      repeat (3) @(posedge clk);
      #1 v = int'(rd_cell);
      rd_mode = 0;
   endtask

   task automatic sweep();
      rd_mode = 1;
      repeat (67) @(posedge clk);
      #1 rd_mode = 0;
   endtask

   // Drop request raised during a scan and held through its end must not act.
   task automatic ignored_drop_test();
      int n = 0;
      int seen = 0;
      int e_win, e_lat;
      model_scan(e_win, e_lat);
      mon_en = 1'b0;
      @(posedge clk); #1;
      check_for_winner = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      drop_a_piece = 1'b1;
      col = 3'd0;
      turn = 1'b0;
      while (!done_check_winner && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      chk("ign_winner", int'(winner), e_win);
      chk("ign_check_done", int'(done_check_winner), 1);
      check_for_winner = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (done_drop_piece) seen = 1;
      end
      chk("ign_no_drop", seen, 0);
      drop_a_piece = 1'b0;
      exp_winner = e_win;
      settle();
   endtask

   task automatic reset_mid_scan();
      int lat, ok;
      mon_en = 1'b0;
      @(posedge clk); #1;
      check_for_winner = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("midscan_busy", int'(done_check_winner), 0);
      reset = 1'b1;
      check_for_winner = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("midscan_rst_done", int'(done_check_winner), 0);
      chk("midscan_rst_winner", int'(winner), 0);
      chk("midscan_rst_full", int'(board_full), 0);
      model_clear();
      do_drop(0, 1, lat, ok);
      chk("post_rst_drop_lat", lat, 2);
      chk("post_rst_drop_ok", ok, 1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int lat, ok, win, v;
      model_clear();
      repeat (3) @(posedge clk);
      do_reset();
      sweep();

      // Alternating stack in column 3.
      for (int i = 0; i < 4; i++) do_drop(3, i % 2, lat, ok);
      chk("pin_row3_latency", lat, 5);
      chk("pin_row3_ok", ok, 1);
      read_cell(0, 3, v); chk("pin_cell_0_3", v, 1);
      read_cell(1, 3, v); chk("pin_cell_1_3", v, 2);
      read_cell(2, 3, v); chk("pin_cell_2_3", v, 1);
      read_cell(3, 3, v); chk("pin_cell_3_3", v, 2);
      read_cell(6, 3, v); chk("pin_cell_oob", v, 0);

      // Full column and illegal column.
      for (int i = 0; i < ROWS; i++) do_drop(6, i % 2, lat, ok);
      do_drop(6, 0, lat, ok);
      chk("pin_full_col_latency", lat, 7);
      chk("pin_full_col_ok", ok, 0);
      do_drop(7, 1, lat, ok);
      chk("pin_bad_col_latency", lat, 2);
      chk("pin_bad_col_ok", ok, 0);
      sweep();
      do_check(lat, win);
      chk("pin_nowin_latency", lat, 169);
      chk("pin_nowin_winner", win, 0);
      ignored_drop_test();
      sweep();

      // Horizontal red line along the bottom.
      do_reset();
      for (int c = 0; c < 4; c++) do_drop(c, 0, lat, ok);
      do_check(lat, win);
      chk("pin_hwin_winner", win, 1);
      chk("pin_hwin_latency", lat, 2);

      // Yellow anti-diagonal (0,6),(1,5),(2,4),(3,3) on filler.
      do_reset();
      do_drop(3, 0, lat, ok); do_drop(3, 1, lat, ok); do_drop(3, 0, lat, ok);
      do_drop(4, 0, lat, ok); do_drop(4, 1, lat, ok);
      do_drop(5, 0, lat, ok);
      do_drop(6, 1, lat, ok); do_drop(5, 1, lat, ok);
      do_drop(4, 1, lat, ok); do_drop(3, 1, lat, ok);
      do_check(lat, win);
      chk("pin_adiag_winner", win, 1);
      chk("pin_adiag_latency", lat, 29);
      reset_mid_scan();
      sweep();

      // Three in a row at the right edge: no wrap-around.
      do_reset();
      for (int c = 4; c < COLS; c++) do_drop(c, 0, lat, ok);
      do_drop(0, 1, lat, ok);
      do_check(lat, win);
      chk("pin_edge_winner", win, 0);
      chk("pin_edge_latency", lat, 169);

      // Fill the whole board.
      do_reset();
      for (int c = 0; c < COLS; c++)
         for (int r = 0; r < ROWS; r++) begin
            if (c == COLS - 1 && r == ROWS - 1) chk("pin_not_full", int'(board_full), 0);
            do_drop(c, (r + c) % 2, lat, ok);
         end
      chk("pin_full", int'(board_full), 1);
      do_drop(2, 0, lat, ok);
      chk("pin_full_board_ok", ok, 0);
      do_check(lat, win);
      sweep();

      // Randomized play.
      do_reset();
      for (int i = 0; i < 150; i++) begin
         if (i % 50 == 49) do_reset();
         if ($urandom_range(0, 4) == 0) do_check(lat, win);
         else do_drop($urandom_range(0, 7), $urandom_range(0, 1), lat, ok);
      end
      sweep();

      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
